// File: rtl/decomp_pkg.sv
// Code, sub-code and length constants shared by the word encoder and its decoder.
package decomp_pkg;

    typedef enum logic [1:0] {
        ZERO   = 2'b00,
        UNCOMP = 2'b01,
        MATCH  = 2'b10,
        EXT    = 2'b11
    } code_e;

    typedef enum logic [1:0] {
        Z16  = 2'b00,
        Z8   = 2'b01,
        PART = 2'b10,
        RSVD = 2'b11
    } bak_e;

    localparam logic [5:0] LEN_ZERO   = 6'd2;
    localparam logic [5:0] LEN_MATCH  = 6'd6;
    localparam logic [5:0] LEN_Z8     = 6'd12;
    localparam logic [5:0] LEN_PART   = 6'd16;
    localparam logic [5:0] LEN_Z16    = 6'd20;
    localparam logic [5:0] LEN_UNCOMP = 6'd34;

endpackage

// File: rtl/word_encoder_if.sv
// Handshake and result bundle of the word encoder; master drives words in, slave is the encoder.
interface word_encoder_if #(
    parameter int WORD    = 16,
    parameter int WIDTH   = 32,
    parameter int I_WORD2 = 34
);
    localparam int IDX_W = $clog2(WORD);

    logic               i_valid;
    logic               o_ready;
    logic [WIDTH-1:0]   i_data;
    logic               o_valid;
    logic               i_ready;
    logic [1:0]         o_codes;
    logic [1:0]         o_codes_bak;
    logic [IDX_W-1:0]   o_idx;
    logic [I_WORD2-1:0] o_word;
    logic [5:0]         o_len;

    modport master (
        output i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_codes, o_codes_bak, o_idx, o_word, o_len
    );

    modport slave (
        input  i_valid, i_data, i_ready,
        output o_ready, o_valid, o_codes, o_codes_bak, o_idx, o_word, o_len
    );
endinterface

// File: rtl/dict_match.sv
// Parallel compare of one word against every valid dictionary entry; lowest index wins.
module dict_match #(
    parameter int WORD  = 16,
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(WORD)
) (
    input  logic [WORD-1:0][WIDTH-1:0] dict,
    input  logic [WORD-1:0]            ent_vld,
    input  logic [WIDTH-1:0]           data,
    output logic                       full_hit,
    output logic [IDX_W-1:0]           full_idx,
    output logic                       part_hit,
    output logic [IDX_W-1:0]           part_idx
);
    always_comb begin
        full_hit = 1'b0;
        full_idx = '0;
        part_hit = 1'b0;
        part_idx = '0;
        // Scan downward so the last hit recorded is the lowest index.
        for (int i = WORD - 1; i >= 0; i--) begin
            if (ent_vld[i] && dict[i] == data) begin
                full_hit = 1'b1;
                full_idx = IDX_W'(i);
            end
            if (ent_vld[i] && dict[i][WIDTH-1:8] == data[WIDTH-1:8]) begin
                part_hit = 1'b1;
                part_idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/word_encoder.sv
// Dictionary word compressor with a one-deep output register and FIFO-replacement dictionary.
// Optional ENCODER_STATS_EN adds saturating handed-off word and bit counters.
module word_encoder
    import decomp_pkg::*;
#(
    parameter int WORD    = 16,
    parameter int WIDTH   = 32,
    parameter int I_WORD2 = 34
) (
    input  logic           i_clk,
    input  logic           i_reset,
    word_encoder_if.slave  bus
`ifdef ENCODER_STATS_EN
    ,
    output logic [31:0]    o_word_cnt,
    output logic [31:0]    o_bit_cnt
`endif
);
    localparam int IDX_W = $clog2(WORD);

    logic [WORD-1:0][WIDTH-1:0] dict_q, dict_d;
    logic [WORD-1:0]            ent_vld_q, ent_vld_d;
    logic [IDX_W-1:0]           wptr_q, wptr_d;

    logic               o_valid_q, o_valid_d;
    logic [1:0]         codes_q, codes_d;
    logic [1:0]         bak_q, bak_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [I_WORD2-1:0] word_q, word_d;
    logic [5:0]         len_q, len_d;

    logic             ready;
    logic             accept;
    logic             full_hit, part_hit;
    logic [IDX_W-1:0] full_idx, part_idx;

    code_e              enc_code;
    bak_e               enc_bak;
    logic [IDX_W-1:0]   enc_idx;
    logic [I_WORD2-1:0] enc_word;
    logic [5:0]         enc_len;
    logic               enc_insert;

    assign ready  = !o_valid_q || bus.i_ready;
    assign accept = bus.i_valid && ready;

    dict_match #(
        .WORD  (WORD),
        .WIDTH (WIDTH)
    ) u_dict_match (
        .dict     (dict_q),
        .ent_vld  (ent_vld_q),
        .data     (bus.i_data),
        .full_hit (full_hit),
        .full_idx (full_idx),
        .part_hit (part_hit),
        .part_idx (part_idx)
    );

    always_comb begin
        enc_code   = UNCOMP;
        enc_bak    = Z16;
        enc_idx    = '0;
        enc_word   = I_WORD2'(bus.i_data);
        enc_len    = LEN_UNCOMP;
        enc_insert = 1'b1;
        if (bus.i_data == '0) begin
            enc_code   = ZERO;
            enc_word   = '0;
            enc_len    = LEN_ZERO;
            enc_insert = 1'b0;
        end else if (full_hit) begin
            enc_code   = MATCH;
            enc_idx    = full_idx;
            enc_word   = '0;
            enc_len    = LEN_MATCH;
            enc_insert = 1'b0;
        end else if (bus.i_data[WIDTH-1:8] == '0) begin
            enc_code   = EXT;
            enc_bak    = Z8;
            enc_word   = I_WORD2'(bus.i_data[7:0]);
            enc_len    = LEN_Z8;
            enc_insert = 1'b0;
        end else if (part_hit) begin
            enc_code   = EXT;
            enc_bak    = PART;
            enc_idx    = part_idx;
            enc_word   = I_WORD2'(bus.i_data[7:0]);
            enc_len    = LEN_PART;
        end else if (bus.i_data[WIDTH-1:16] == '0) begin
            enc_code   = EXT;
            enc_bak    = Z16;
            enc_word   = I_WORD2'(bus.i_data[15:0]);
            enc_len    = LEN_Z16;
            enc_insert = 1'b0;
        end
    end

    // Inserts land at the edge, so the very next accepted word already sees them.
    always_comb begin
        dict_d    = dict_q;
        ent_vld_d = ent_vld_q;
        wptr_d    = wptr_q;
        if (accept && enc_insert) begin
            dict_d[wptr_q]    = bus.i_data;
            ent_vld_d[wptr_q] = 1'b1;
            wptr_d            = wptr_q + 1'b1;
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        codes_d   = codes_q;
        bak_d     = bak_q;
        idx_d     = idx_q;
        word_d    = word_q;
        len_d     = len_q;
        if (accept) begin
            o_valid_d = 1'b1;
            codes_d   = enc_code;
            bak_d     = enc_bak;
            idx_d     = enc_idx;
            word_d    = enc_word;
            len_d     = enc_len;
        end else if (bus.i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        dict_q <= dict_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ent_vld_q <= '0;
            wptr_q    <= '0;
            o_valid_q <= 1'b0;
            codes_q   <= '0;
            bak_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            len_q     <= '0;
        end else begin
            ent_vld_q <= ent_vld_d;
            wptr_q    <= wptr_d;
            o_valid_q <= o_valid_d;
            codes_q   <= codes_d;
            bak_q     <= bak_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            len_q     <= len_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_codes     = codes_q;
    assign bus.o_codes_bak = bak_q;
    assign bus.o_idx       = idx_q;
    assign bus.o_word      = word_q;
    assign bus.o_len       = len_q;

`ifdef ENCODER_STATS_EN
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] bit_cnt_q, bit_cnt_d;
    logic [32:0] bit_sum;

    always_comb begin
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bit_sum    = {1'b0, bit_cnt_q} + {27'd0, len_q};
        if (o_valid_q && bus.i_ready) begin
            if (word_cnt_q != '1) begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
            bit_cnt_d = bit_sum[32] ? '1 : bit_sum[31:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_word_cnt = word_cnt_q;
    assign o_bit_cnt  = bit_cnt_q;
`endif
endmodule

// File: tb/tb_word_encoder.sv
// Scoreboard bench for word_encoder: expected encodings queued at accept, checked at hand-off.
module tb_word_encoder;
    import decomp_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  codes;
        logic [1:0]  bak;
        logic [3:0]  idx;
        logic [33:0] word;
        logic [5:0]  len;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    word_encoder_if #(.WORD(16), .WIDTH(32), .I_WORD2(34)) bus ();

`ifdef ENCODER_STATS_EN
    logic [31:0] word_cnt;
    logic [31:0] bit_cnt;
`endif

    word_encoder #(.WORD(16), .WIDTH(32), .I_WORD2(34)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
`ifdef ENCODER_STATS_EN
        ,
        .o_word_cnt (word_cnt),
        .o_bit_cnt  (bit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: a hand-off happens on the next rising edge when o_valid && i_ready.
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output codes=%b len=%0d expected no output", bus.o_codes, bus.o_len);
            end else begin
                exp_t e;
                logic ok;
                e  = sb.pop_front();
                ok = (bus.o_codes === e.codes) && (bus.o_word === e.word) && (bus.o_len === e.len);
                if (e.codes == EXT && bus.o_codes_bak !== e.bak) ok = 1'b0;
                if ((e.codes == MATCH || (e.codes == EXT && e.bak == PART)) && bus.o_idx !== e.idx) ok = 1'b0;
                if (!ok) begin
                    n_err++;
                    $display("FAIL encode_%08h got codes=%b bak=%b idx=%0d word=%h len=%0d expected codes=%b bak=%b idx=%0d word=%h len=%0d",
                             e.data, bus.o_codes, bus.o_codes_bak, bus.o_idx, bus.o_word, bus.o_len,
                             e.codes, e.bak, e.idx, e.word, e.len);
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] c, input logic [1:0] b,
                        input logic [3:0] ix, input logic [33:0] w, input logic [5:0] l);
        exp_t e;
        int   n;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!bus.o_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout_%08h o_ready=%b expected 1", d, bus.o_ready);
        end else begin
            e.data = d; e.codes = c; e.bak = b; e.idx = ix; e.word = w; e.len = l;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        wait_drain();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_codes !== 2'b00 || bus.o_codes_bak !== 2'b00 ||
            bus.o_idx !== 4'd0 || bus.o_word !== 34'd0 || bus.o_len !== 6'd0 || bus.o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state got valid=%b codes=%b bak=%b idx=%0d word=%h len=%0d ready=%b expected all 0, ready 1",
                     bus.o_valid, bus.o_codes, bus.o_codes_bak, bus.o_idx, bus.o_word, bus.o_len, bus.o_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_and_full();
        send(32'h00000000, ZERO,   Z16, 4'd0, 34'd0,          LEN_ZERO);
        send(32'hDEADBEEF, UNCOMP, Z16, 4'd0, 34'h0DEADBEEF,  LEN_UNCOMP);
        send(32'hDEADBEEF, MATCH,  Z16, 4'd0, 34'd0,          LEN_MATCH);
    endtask

    task automatic test_partial();
        send(32'hDEADBE12, EXT,   PART, 4'd0, 34'h12, LEN_PART);
        send(32'hDEADBE12, MATCH, Z16,  4'd1, 34'd0,  LEN_MATCH);
    endtask

    task automatic test_zero_ext();
        send(32'h00000023, EXT, Z8,  4'd0, 34'h23,   LEN_Z8);
        send(32'h00001234, EXT, Z16, 4'd0, 34'h1234, LEN_Z16);
        send(32'h00001234, EXT, Z16, 4'd0, 34'h1234, LEN_Z16);
        send(32'h00000023, EXT, Z8,  4'd0, 34'h23,   LEN_Z8);
    endtask

    task automatic test_lowest_index();
        do_reset();
        send(32'hCAFE0011, UNCOMP, Z16,  4'd0, 34'h0CAFE0011, LEN_UNCOMP);
        send(32'hCAFE0022, EXT,    PART, 4'd0, 34'h22,        LEN_PART);
        send(32'hCAFE0033, EXT,    PART, 4'd0, 34'h33,        LEN_PART);
        send(32'hCAFE0022, MATCH,  Z16,  4'd1, 34'd0,         LEN_MATCH);
    endtask

    task automatic test_fifo_wrap();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            w = {8'(8'h10 + i), 24'h5A5A5A};
            send(w, UNCOMP, Z16, 4'd0, {2'b00, w}, LEN_UNCOMP);
        end
        w = {8'h11, 24'h5A5A5A};
        send(w, MATCH, Z16, 4'd1, 34'd0, LEN_MATCH);
        w = {8'h10, 24'h5A5A5A};
        send(w, UNCOMP, Z16, 4'd0, {2'b00, w}, LEN_UNCOMP);
        w = {8'h20, 24'h5A5A5A};
        send(w, MATCH, Z16, 4'd0, 34'd0, LEN_MATCH);
    endtask

    task automatic test_stall_and_reset();
        exp_t e;
        do_reset();
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'h00000023;
        @(negedge clk);
        e.data = 32'h23; e.codes = EXT; e.bak = Z8; e.idx = 4'd0; e.word = 34'h23; e.len = LEN_Z8;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.i_data = 32'h00001234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b1 || bus.o_codes !== EXT ||
                bus.o_codes_bak !== Z8 || bus.o_word !== 34'h23 || bus.o_len !== LEN_Z8) begin
                n_err++;
                $display("FAIL stall_hold_%0d got ready=%b valid=%b codes=%b bak=%b word=%h len=%0d expected 0 1 11 01 23 12",
                         k, bus.o_ready, bus.o_valid, bus.o_codes, bus.o_codes_bak, bus.o_word, bus.o_len);
            end
            @(posedge clk);
            #1;
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        e.data = 32'h1234; e.codes = EXT; e.bak = Z16; e.idx = 4'd0; e.word = 34'h1234; e.len = LEN_Z16;
        if (bus.o_ready) sb.push_back(e);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        wait_drain();

        // Park a DEADBEEF in the output register, then reset underneath it.
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.o_valid !== 1'b0 || bus.o_codes !== 2'b00 || bus.o_len !== 6'd0) begin
            n_err++;
            $display("FAIL midstream_reset got valid=%b codes=%b len=%0d expected 0 00 0",
                     bus.o_valid, bus.o_codes, bus.o_len);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'hDEADBEEF, UNCOMP, Z16, 4'd0, 34'h0DEADBEEF, LEN_UNCOMP);
        send(32'hDEADBEEF, MATCH,  Z16, 4'd0, 34'd0,         LEN_MATCH);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_data  = '0;
        test_reset();
        test_zero_and_full();
        test_partial();
        test_zero_ext();
        test_lowest_index();
        test_fifo_wrap();
        test_stall_and_reset();
        wait_drain();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached expected finish");
        $fatal(1);
    end
endmodule

// File: doc/word_encoder.md
WORD_ENCODER -- requirements
Module: word_encoder

Interface
REQ-001 SHALL have parameter WORD, default 16, meaning the number of dictionary entries (power of two).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the data word width.
REQ-003 SHALL have parameter I_WORD2, default 34, meaning the payload width.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports i_valid (input, 1), o_ready (output, 1) and i_data (input, WIDTH): the input handshake and the word to compress.
REQ-007 SHALL have ports o_valid (output, 1) and i_ready (input, 1): the output handshake.
REQ-008 SHALL have port o_codes, output, 2 bits: the primary code.
REQ-009 SHALL have port o_codes_bak, output, 2 bits: the secondary code, meaningful only when o_codes=11.
REQ-010 SHALL have port o_idx, output, $clog2(WORD) bits: the dictionary index.
REQ-011 SHALL have port o_word, output, I_WORD2 bits: the payload, right-aligned with unused bits 0.
REQ-012 SHALL have port o_len, output, 6 bits: the total encoded bit length.

Function
REQ-013 SHALL accept a word when i_valid&&o_ready, where o_ready = !o_valid || i_ready.
REQ-014 SHALL present the result one cycle after acceptance (o_valid=1) and hold o_valid and all outputs stable while o_valid&&!i_ready.
REQ-015 SHALL allow back-to-back accepts on a simultaneous pop and accept, for a throughput of 1 word/cycle.
REQ-016 SHALL compare i_data against all valid dictionary entries at the accept cycle; when several entries match, the lowest index wins.
REQ-017 SHALL pick the first matching encoding in this priority order (shortest first):
 - data==0: codes 00, len 2.
 - full match: codes 10, idx, len 6.
 - data[31:8]==0: codes 11, bak 01, payload[7:0], len 12.
 - partial match (entry[31:8]==data[31:8]): codes 11, bak 10, idx, payload[7:0]=data[7:0], len 16.
 - data[31:16]==0: codes 11, bak 00, payload[15:0], len 20.
 - otherwise: codes 01, payload[31:0], len 34.
REQ-018 SHALL never emit codes 11/bak 11, which is reserved.
REQ-019 SHALL, on accept of an uncompressed or partial-match word, write data into the entry at the write pointer, set that entry valid, and increment the pointer modulo WORD (wrap 15->0, FIFO replacement).
REQ-020 SHALL let a word accepted in cycle N+1 see the dictionary insert from cycle N.
REQ-021 SHALL not modify the dictionary for zero, full-match or zero-extended words.
REQ-022 SHALL, once all WORD entries are valid, overwrite the oldest entry with each further insert.

Reset
REQ-023 SHALL, on i_reset assertion, asynchronously clear o_valid, o_codes, o_codes_bak, o_idx, o_word, o_len, all entry-valid bits and the write pointer to 0.
REQ-024 SHALL discard an in-flight output on a mid-stream reset without emitting it; the first post-reset word SHALL see an empty dictionary.

Configuration
REQ-025 SHALL, when ENCODER_STATS_EN is defined, add outputs o_word_cnt (32) and o_bit_cnt (32) counting handed-off words and the summed o_len of handed-off words (increment on o_valid&&i_ready), both saturating at all-ones and cleared by reset.
REQ-026 SHALL, when ENCODER_STATS_EN is undefined, have neither those ports nor the counter logic.

Structure
REQ-027 SHALL place in the shared package decomp_pkg: the code constants (ZERO=00, UNCOMP=01, MATCH=10, EXT=11), the bak constants (Z16=00, Z8=01, PART=10, RSVD=11) and the per-encoding length constants, shared with the decoder.
REQ-028 SHALL implement the combinational compare as one sub-module, dict_match, taking the dictionary, valid bits and data and producing the full/partial hit flags and lowest indices.

Verification
REQ-029 SHALL cover: after reset, send 0x00000000 -> codes 00, len 2, no dictionary write.
REQ-030 SHALL cover: send 0xDEADBEEF then 0xDEADBEEF -> first 01/payload DEADBEEF/len 34; second 10, idx 0, len 6.
REQ-031 SHALL cover: with DEADBEEF in entry 0, send 0xDEADBE12 -> 11/10, idx 0, payload 0x12, len 16, written to entry 1.
REQ-032 SHALL cover: send 0x00000023 -> 11/01, payload 0x23, len 12; send 0x00001234 -> 11/00, payload 0x1234, len 20.
REQ-033 SHALL cover: insert 17 distinct uncompressed words -> the 17th overwrites entry 0; resending word 1 -> 01; resending word 2 -> 10 idx 1.
REQ-034 SHALL cover: hold i_ready=0 for 3 cycles with i_valid=1 -> o_ready=0 and outputs stable; assert i_reset mid-stream -> o_valid=0 immediately, and the next DEADBEEF encodes as 01.
